mdu_sequencer: RTL and testbench

Multi-cycle multiply/divide unit for the MIPS pipeline, sitting beside the EX-stage ALU. Accepts R-type MULT/MULTU/DIV/DIVU from ID/EX and iterates one bit per cycle (radix-2 shift-add / restoring divide). Holds results in architectural HI/LO and serves MFHI/MFLO. Drives a stall to the hazard/PC logic while an operation is in flight and a dependent or new MDU instruction arrives.

---
 rtl/mdu_pkg.sv | 29 ++
 rtl/mdu_sign_fix.sv | 30 +++
 rtl/mdu_sequencer.sv | 148 ++++++++++++++
 tb/tb_mdu_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared funct codes, FSM states and op kinds for the multiply/divide unit.
package mdu_pkg;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    // Encoding matches funct[1:0] of the MDU group
    typedef enum logic [1:0] {
        OP_MULT,
        OP_MULTU,
        OP_DIV,
        OP_DIVU
    } op_t;

    function automatic logic is_mdu(input logic [5:0] f);
        return f inside {F_MULT, F_MULTU, F_DIV, F_DIVU};
    endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate of the raw product or quotient/remainder.
module mdu_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic               mul,
    input  logic               neg_q,
    input  logic               neg_r,
    input  logic [2*WIDTH-1:0] raw,
    output logic [WIDTH-1:0]   fx_hi,
    output logic [WIDTH-1:0]   fx_lo
);

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    always_comb begin
        prod = neg_q ? -raw : raw;
        quo  = neg_q ? -raw[WIDTH-1:0] : raw[WIDTH-1:0];
        rem  = neg_r ? -raw[2*WIDTH-1:WIDTH] : raw[2*WIDTH-1:WIDTH];
        if (mul) begin
            fx_hi = prod[2*WIDTH-1:WIDTH];
            fx_lo = prod[WIDTH-1:0];
        end else begin
            fx_hi = rem;
            fx_lo = quo;
        end
    end

endmodule

// File: rtl/mdu_sequencer.sv
// Radix-2 shift-add multiply / restoring divide with architectural HI/LO.
// Build option: MDU_EARLY_OUT_EN ends multiplies once the multiplier runs out.
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             kill,
    input  logic [5:0]       Func,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] mf_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t             state;
    op_t                op;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a, b, acc;
    logic               neg_q, neg_r, fix_wr;

    logic               go, mf_req, sgn, div_f, is_div, early;
    logic [WIDTH-1:0]   rs_mag, rt_mag, nxt_acc, nxt_b, fx_hi, fx_lo;
    logic [WIDTH:0]     mul_sum, div_tmp, div_sub;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod;

    assign go     = start & ~kill & is_mdu(Func);
    assign mf_req = start & ~kill & (Func == F_MFHI || Func == F_MFLO);
    assign busy   = (state != S_IDLE);
    assign stall  = busy & (go | mf_req);
    assign sgn    = (Func == F_MULT) || (Func == F_DIV);
    assign div_f  = (Func == F_DIV) || (Func == F_DIVU);
    assign is_div = (op == OP_DIV) || (op == OP_DIVU);
    assign rs_mag = (sgn & rs_val[WIDTH-1]) ? -rs_val : rs_val;
    assign rt_mag = (sgn & rt_val[WIDTH-1]) ? -rt_val : rt_val;

    always_comb begin
        mf_data = '0;
        if (Func == F_MFHI)
            mf_data = hi;
        else if (Func == F_MFLO)
            mf_data = lo;
    end

    // acc:b is the product register (mul) or remainder:dividend/quotient (div)
    always_comb begin
        mul_sum = {1'b0, acc} + {1'b0, (b[0] ? a : '0)};
        div_tmp = {acc, b[WIDTH-1]};
        div_ge  = (div_tmp >= {1'b0, a});
        div_sub = div_tmp - {1'b0, a};
        if (is_div) begin
            nxt_acc = div_ge ? div_sub[WIDTH-1:0] : div_tmp[WIDTH-1:0];
            nxt_b   = {b[WIDTH-2:0], div_ge};
        end else begin
            nxt_acc = mul_sum[WIDTH:1];
            nxt_b   = {mul_sum[0], b[WIDTH-1:1]};
        end
    end

`ifdef MDU_EARLY_OUT_EN
    logic [WIDTH-1:0] rem_mask;
    assign rem_mask = ~({WIDTH{1'b1}} << (cnt - CNT_W'(1)));
    assign early    = ~is_div & ((nxt_b & rem_mask) == '0);
    // cnt holds the iterations skipped; they only shift zeros in
    assign prod     = {acc, b} >> cnt;
`else
    assign early    = 1'b0;
    assign prod     = {acc, b};
`endif

    mdu_sign_fix #(.WIDTH(WIDTH)) u_fix (
        .mul   (~is_div),
        .neg_q (neg_q),
        .neg_r (neg_r),
        .raw   (prod),
        .fx_hi (fx_hi),
        .fx_lo (fx_lo)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            op     <= OP_MULT;
            cnt    <= '0;
            a      <= '0;
            b      <= '0;
            acc    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            fix_wr <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: if (go) begin
                    op     <= op_t'(Func[1:0]);
                    acc    <= '0;
                    a      <= div_f ? rt_mag : rs_mag;
                    b      <= div_f ? rs_mag : rt_mag;
                    neg_q  <= sgn & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                    neg_r  <= sgn & rs_val[WIDTH-1];
                    cnt    <= CNT_W'(WIDTH);
                    fix_wr <= 1'b0;
                    state  <= S_CALC;
                    if (div_f && rt_val == '0) begin
                        acc   <= rs_val;
                        b     <= '1;
                        neg_q <= 1'b0;
                        neg_r <= 1'b0;
                        cnt   <= '0;
                        state <= S_FIX;
                    end
                end
                S_CALC: begin
                    acc <= nxt_acc;
                    b   <= nxt_b;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1) || early)
                        state <= S_FIX;
                end
                S_FIX: if (!fix_wr) begin
                    acc    <= fx_hi;
                    b      <= fx_lo;
                    fix_wr <= 1'b1;
                end else begin
                    hi     <= acc;
                    lo     <= b;
                    done   <= 1'b1;
                    fix_wr <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed vector bench for mdu_sequencer: results, latency, stall and reset.
module tb_mdu_sequencer;
    import mdu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         kill = 1'b0;
    logic [5:0]   Func = 6'b0;
    logic [W-1:0] rs_val = '0;
    logic [W-1:0] rt_val = '0;
    logic         busy, stall, done;
    logic [W-1:0] mf_data, hi, lo;

    int vecs = 0;
    int errs = 0;

    mdu_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .kill    (kill),
        .Func    (Func),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .busy    (busy),
        .stall   (stall),
        .done    (done),
        .mf_data (mf_data),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]   f;
        logic [W-1:0] rs;
        logic [W-1:0] rt;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           lat;
        int           eol;
    } vec_t;

    vec_t tv[11];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic [5:0] f, input logic [W-1:0] rs,
                         input logic [W-1:0] rt);
        @(negedge clk);
        Func   = f;
        rs_val = rs;
        rt_val = rt;
        kill   = 1'b0;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        Func  = F_MFLO;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            #1;
        end while (!done && n < 100);
        chk("done_seen", {63'b0, done}, 64'd1);
    endtask

    initial begin
        int  n;
        logic ok;
        tv[0]  = '{F_MULT,  32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 34, 34};
        tv[1]  = '{F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 34, 34};
        tv[2]  = '{F_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 34, 34};
        tv[3]  = '{F_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       34, 34};
        tv[4]  = '{F_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 34, 34};
        tv[5]  = '{F_DIV,   32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF, 2,  2};
        tv[6]  = '{F_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 2,  2};
        tv[7]  = '{F_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 34, 34};
        tv[8]  = '{F_DIVU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 34, 34};
        tv[9]  = '{F_MULTU, 32'd3,        32'd0,        32'd0,        32'd0,        34, 3};
        tv[10] = '{F_MULTU, 32'd5,        32'd3,        32'd0,        32'd15,       34, 4};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",  {63'b0, busy},  64'd0);
        chk("rst_done",  {63'b0, done},  64'd0);
        chk("rst_stall", {63'b0, stall}, 64'd0);
        chk("rst_hilo",  {hi, lo},       64'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 11; i++) begin
            issue(tv[i].f, tv[i].rs, tv[i].rt);
            chk($sformatf("v%0d_busy", i), {63'b0, busy}, 64'd1);
            wait_done(n);
`ifdef MDU_EARLY_OUT_EN
            if (tv[i].f == F_MULT || tv[i].f == F_MULTU)
                chk($sformatf("v%0d_lat_max", i), {63'b0, n <= tv[i].eol}, 64'd1);
            else
                chk($sformatf("v%0d_lat", i), 64'(n), 64'(tv[i].lat));
`else
            chk($sformatf("v%0d_lat", i), 64'(n), 64'(tv[i].lat));
`endif
            chk($sformatf("v%0d_hilo", i), {hi, lo}, {tv[i].hi, tv[i].lo});
            chk($sformatf("v%0d_mflo", i), {32'b0, mf_data}, {32'b0, tv[i].lo});
            Func = F_MFHI;
            #1;
            chk($sformatf("v%0d_mfhi", i), {32'b0, mf_data}, {32'b0, tv[i].hi});
        end

        // MFHI behind an in-flight MULTU
        issue(F_MULTU, 32'h10000, 32'h10000);
        repeat (4) @(posedge clk);
        @(negedge clk);
        Func  = F_MFHI;
        start = 1'b1;
        ok    = 1'b1;
        n     = 0;
        do begin
            #1;
            if (!done && !stall)
                ok = 1'b0;
            if (!done) begin
                @(posedge clk);
                n++;
            end
        end while (!done && n < 100);
        chk("mf_done_seen", {63'b0, done},  64'd1);
        chk("mf_stalled",   {63'b0, ok},    64'd1);
        chk("mf_stall_rel", {63'b0, stall}, 64'd0);
        chk("mf_new_hi",    {32'b0, mf_data}, 64'd1);
        @(negedge clk);
        start = 1'b0;

        // Second MULT waits, then is accepted in the done cycle
        issue(F_MULT, 32'd2, 32'd3);
        repeat (3) @(posedge clk);
        @(negedge clk);
        Func   = F_MULT;
        rs_val = 32'd4;
        rt_val = 32'd5;
        start  = 1'b1;
        ok     = 1'b1;
        n      = 0;
        do begin
            @(posedge clk);
            n++;
            #1;
            if (!done && !stall)
                ok = 1'b0;
        end while (!done && n < 100);
        chk("m2_done_seen", {63'b0, done},  64'd1);
        chk("m2_stalled",   {63'b0, ok},    64'd1);
        chk("m2_stall_rel", {63'b0, stall}, 64'd0);
        chk("m2_first",     {hi, lo},       64'd6);
        @(posedge clk);
        #1;
        start = 1'b0;
        Func  = 6'b0;
        chk("m2_accepted", {63'b0, busy}, 64'd1);
        wait_done(n);
`ifndef MDU_EARLY_OUT_EN
        chk("m2_lat", 64'(n), 64'd34);
`endif
        chk("m2_second", {hi, lo}, 64'd20);

        // Killed MULT and a non-MDU funct must not start anything
        @(negedge clk);
        Func   = F_MULT;
        rs_val = 32'd9;
        rt_val = 32'd9;
        kill   = 1'b1;
        start  = 1'b1;
        #1;
        chk("kill_stall", {63'b0, stall}, 64'd0);
        @(posedge clk);
        #1;
        chk("kill_busy", {63'b0, busy}, 64'd0);
        @(negedge clk);
        kill = 1'b0;
        Func = 6'b100000;
        @(posedge clk);
        #1;
        chk("other_busy", {63'b0, busy}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("kill_hilo", {hi, lo}, 64'd20);
        start = 1'b0;

        // Asynchronous reset in the middle of a divide
        issue(F_DIV, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #1;
        chk("pre_rst_busy", {63'b0, busy}, 64'd1);
        rst = 1'b0;
        #1;
        chk("arst_busy", {63'b0, busy}, 64'd0);
        chk("arst_hilo", {hi, lo},      64'd0);
        chk("arst_done", {63'b0, done}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        ok  = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            ok = ok | done;
        end
        chk("arst_no_done", {63'b0, ok},   64'd0);
        chk("arst_hilo2",   {hi, lo},      64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
